// File: rtl/uart_pkg.sv
// uart_pkg: UART state encoding, legal parameter ranges and frame-length helper shared by TX and RX.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam int DATA_BITS_MIN = 5;
    localparam int DATA_BITS_MAX = 9;
    localparam int STOP_BITS_MIN = 1;
    localparam int STOP_BITS_MAX = 2;

    function automatic int frame_clocks(input int clk_div, input int data_bits,
                                        input int stop_bits, input bit parity);
        return (1 + data_bits + int'(parity) + stop_bits) * clk_div;
    endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// uart_tx_buffered_if: character load/ready handshake and FIFO occupancy of the buffered UART transmitter.
interface uart_tx_buffered_if #(
    parameter int DATA_BITS  = 7,
    parameter int FIFO_DEPTH = 8
);
    logic                              load;
    logic [DATA_BITS-1:0]              in;
    logic                              ready;
    logic [$clog2(FIFO_DEPTH+1)-1:0]   level;

    modport master (output load, in, input ready, level);
    modport slave  (input load, in, output ready, level);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two synchronous FIFO with wrap-bit pointers, full/empty flags and occupancy.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_en,
    input  logic [WIDTH-1:0]               wr_data,
    input  logic                           rd_en,
    output logic [WIDTH-1:0]               rd_data,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             do_wr, do_rd;

    assign empty   = wr_ptr_q == rd_ptr_q;
    assign full    = wr_ptr_q == {~rd_ptr_q[AW], rd_ptr_q[AW-1:0]};
    assign level   = wr_ptr_q - rd_ptr_q;
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        do_wr    = wr_en && !full;
        do_rd    = rd_en && !empty;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_wr};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_rd};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-buffered LSB-first UART transmitter; parity bit built only with UART_TX_PARITY_EN.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 32,
    parameter int DATA_BITS  = 7,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_tx_buffered_if.slave  bus,
    output logic               tx,
    output logic               busy
);
    localparam int CW = $clog2(CLK_DIV);

    if (CLK_DIV < 2 || CLK_DIV > 65535 ||
        DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX ||
        STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_param
        $error("uart_tx_buffered: illegal parameter set");
    end

    uart_state_e          state_q, state_d;
    logic [CW-1:0]        baud_q, baud_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, head;
    logic                 tx_q, tx_d;
    logic                 empty, full, pop, bit_end;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_d;
`endif

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (bus.load),
        .wr_data (bus.in),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .level   (bus.level)
    );

    assign bus.ready = !full;
    assign tx        = tx_q;
    assign busy      = state_q != IDLE || !empty;
    assign bit_end   = baud_q == CW'(CLK_DIV - 1);

    always_comb begin
        state_d = state_q;
        baud_d  = (state_q == IDLE || bit_end) ? '0 : baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        if (state_q == IDLE) begin
            if (!empty) begin
                state_d = START;
                pop     = 1'b1;
                shift_d = head;
            end
        end else if (bit_end) begin
            case (state_q)
                START: state_d = DATA;
                DATA: begin
                    shift_d = shift_q >> 1;
                    if (bit_q == 4'(DATA_BITS - 1))
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    else
                        bit_d = bit_q + 1'b1;
                end
`ifdef UART_TX_PARITY_EN
                PARITY: state_d = STOP;
`endif
                STOP: begin
                    // Chain straight into the next start bit so queued frames leave no idle gap
                    if (bit_q != 4'(STOP_BITS - 1)) begin
                        bit_d = bit_q + 1'b1;
                    end else if (!empty) begin
                        state_d = START;
                        pop     = 1'b1;
                        shift_d = head;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (state_d != state_q) bit_d = '0;
`ifdef UART_TX_PARITY_EN
        par_d = pop ? (^head) ^ 1'(PARITY_ODD) : par_q;
`endif
        // tx is registered from the next-state view so the line never glitches
        tx_d = (state_d == START) ? 1'b0 :
               (state_d == DATA)  ? shift_d[0] :
`ifdef UART_TX_PARITY_EN
               (state_d == PARITY) ? par_d :
`endif
               1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: scoreboard bench; per-DUT serial monitors decode frames and check them against queued characters.
module tb_uart_tx_buffered;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int CDIV = 4;
    localparam int FR0  = PAR ? 40 : 36;
    localparam int FR1  = PAR ? 48 : 44;

    logic       clk = 1'b0;
    logic [2:0] rst_n, tx_w, busy_w, rdy_w;
    logic [3:0] lvl_w [3];
    int         cyc = 0, n_tests = 0, n_fail = 0;
    logic [8:0] q0[$], q1[$], q2[$];
    int         st1[$];
    int         last_start [3];
    logic       last_par [3];

    uart_tx_buffered_if #(.DATA_BITS(7), .FIFO_DEPTH(8)) if0 ();
    uart_tx_buffered_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if1 ();
    uart_tx_buffered_if #(.DATA_BITS(7), .FIFO_DEPTH(8)) if2 ();

    uart_tx_buffered #(.CLK_DIV(CDIV)) d0 (
        .clk(clk), .rst_n(rst_n[0]), .bus(if0), .tx(tx_w[0]), .busy(busy_w[0]));
    uart_tx_buffered #(.CLK_DIV(CDIV), .DATA_BITS(8), .STOP_BITS(2), .FIFO_DEPTH(4)) d1 (
        .clk(clk), .rst_n(rst_n[1]), .bus(if1), .tx(tx_w[1]), .busy(busy_w[1]));
    uart_tx_buffered #(.CLK_DIV(CDIV), .PARITY_ODD(1)) d2 (
        .clk(clk), .rst_n(rst_n[2]), .bus(if2), .tx(tx_w[2]), .busy(busy_w[2]));

    assign rdy_w    = {if2.ready, if1.ready, if0.ready};
    assign lvl_w[0] = if0.level;
    assign lvl_w[1] = {1'b0, if1.level};
    assign lvl_w[2] = if2.level;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, got, exp, cyc);
        end
    endtask

    task automatic drv(input int id, input logic l, input logic [8:0] v);
        case (id)
            0: begin if0.load = l; if0.in = v[6:0]; end
            1: begin if1.load = l; if1.in = v[7:0]; end
            default: begin if2.load = l; if2.in = v[6:0]; end
        endcase
    endtask

    task automatic qpush(input int id, input logic [8:0] v);
        case (id)
            0: q0.push_back(v);
            1: q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    function automatic int qsize(input int id);
        return id == 0 ? q0.size() : id == 1 ? q1.size() : q2.size();
    endfunction

    task automatic qpop(input int id, output logic [8:0] v);
        case (id)
            0: v = q0.pop_front();
            1: v = q1.pop_front();
            default: v = q2.pop_front();
        endcase
    endtask

    task automatic mon(input int id, input int nb, input int ns, input logic odd);
        logic [8:0] ch, exp;
        logic b, p, ok, abort;
        forever begin
            @(negedge clk);
            if (rst_n[id] && tx_w[id] === 1'b0) begin
                last_start[id] = cyc;
                if (id == 1) st1.push_back(cyc);
                ch = '0; p = 1'b0; ok = 1'b1; abort = 1'b0; b = 1'b0;
                for (int i = 0; i < 1 + nb + PAR + ns && !abort; i++) begin
                    for (int c = 0; c < CDIV && !abort; c++) begin
                        if (i != 0 || c != 0) @(negedge clk);
                        if (!rst_n[id]) abort = 1'b1;
                        else if (c == 0) b = tx_w[id];
                        else if (tx_w[id] !== b) ok = 1'b0;
                    end
                    if (i == 0) ok = ok && (b === 1'b0);
                    else if (i <= nb) ch[i-1] = b;
                    else if (i == nb + PAR) p = b;
                    else if (b !== 1'b1) ok = 1'b0;
                end
                if (!abort) begin
                    last_par[id] = p;
                    chk($sformatf("frame_shape%0d", id), ok, 1);
                    chk($sformatf("sb_has_entry%0d", id), qsize(id) > 0, 1);
                    if (qsize(id) > 0) begin
                        qpop(id, exp);
                        chk($sformatf("char%0d", id), ch, exp);
`ifdef UART_TX_PARITY_EN
                        chk($sformatf("parity%0d", id), p, (^exp) ^ odd);
`endif
                    end
                end
            end
        end
    endtask

    task automatic wait_idle(input int id, input int lim);
        int n = 0;
        while (busy_w[id] !== 1'b0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("idle_in_time%0d", id), busy_w[id], 0);
    endtask

    initial mon(0, 7, 1, 1'b0);
    initial mon(1, 8, 2, 1'b0);
    initial mon(2, 7, 1, 1'b1);

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, lows;
        rst_n = '0;
        drv(0, 0, 0); drv(1, 0, 0); drv(2, 0, 0);
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_tx", tx_w[d], 1);
            chk("rst_ready", rdy_w[d], 1);
            chk("rst_busy", busy_w[d], 0);
            chk("rst_level", lvl_w[d], 0);
        end
        rst_n = '1;
        @(negedge clk);

        // single 7-bit frame, exact latency and busy fall
        drv(0, 1, 9'h055);
        @(negedge clk);
        drv(0, 0, 0); qpush(0, 9'h055);
        chk("a_level", lvl_w[0], 1);
        chk("a_latency_tx", tx_w[0], 1);
        chk("a_busy", busy_w[0], 1);
        @(negedge clk);
        chk("a_start", tx_w[0], 0);
        chk("a_popped_level", lvl_w[0], 0);
        repeat (FR0 - 1) @(negedge clk);
        chk("a_busy_last_stop", busy_w[0], 1);
        @(negedge clk);
        chk("a_busy_fall", busy_w[0], 0);
        chk("a_tx_idle", tx_w[0], 1);

        // three back-to-back 8N2 frames
        st1.delete();
        chk("b_ready", rdy_w[1], 1);
        drv(1, 1, 9'h0A5); @(negedge clk); qpush(1, 9'h0A5);
        drv(1, 1, 9'h03C); @(negedge clk); qpush(1, 9'h03C);
        drv(1, 1, 9'h0FF); @(negedge clk); qpush(1, 9'h0FF);
        drv(1, 0, 0);
        n = 0;
        while (st1.size() < 3 && n < 3 * FR1 + 20) begin @(negedge clk); n++; end
        chk("b_frames", st1.size(), 3);
        if (st1.size() >= 3) begin
            chk("b_gap1", st1[1] - st1[0], FR1);
            chk("b_gap2", st1[2] - st1[1], FR1);
        end
        wait_idle(1, 2 * FR1 + 10);

        // fill a depth-4 FIFO during a frame; fifth load dropped
        drv(1, 1, 9'h011); @(negedge clk); qpush(1, 9'h011); drv(1, 0, 0);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("c_ready", rdy_w[1], i < 4);
            drv(1, 1, 9'h020 + 9'(i));
            @(negedge clk);
            if (i < 4) qpush(1, 9'h020 + 9'(i));
        end
        drv(1, 0, 0);
        chk("c_level_full", lvl_w[1], 4);
        chk("c_ready_low", rdy_w[1], 0);
        n = 0;
        while (lvl_w[1] == 4 && n < FR1 + 10) begin @(negedge clk); n++; end
        chk("c_level_after_pop", lvl_w[1], 3);
        chk("c_ready_back", rdy_w[1], 1);
        wait_idle(1, 5 * FR1 + 10);

        // load on the same edge as a pop, level 2
        drv(1, 1, 9'h001); @(negedge clk); qpush(1, 9'h001);
        drv(1, 1, 9'h080); @(negedge clk); qpush(1, 9'h080);
        drv(1, 1, 9'h05A); @(negedge clk); qpush(1, 9'h05A);
        drv(1, 0, 0);
        repeat (FR1 - 2) @(negedge clk);
        chk("d_level_before", lvl_w[1], 2);
        chk("d_ready_before", rdy_w[1], 1);
        drv(1, 1, 9'h0C3); @(negedge clk); qpush(1, 9'h0C3); drv(1, 0, 0);
        chk("d_level_same", lvl_w[1], 2);
        chk("d_ready", rdy_w[1], 1);
        chk("d_next_start", tx_w[1], 0);
        wait_idle(1, 4 * FR1 + 10);

        // 7'h07: even parity on d0, odd parity on d2
        drv(0, 1, 9'h007); drv(2, 1, 9'h007);
        @(negedge clk);
        drv(0, 0, 0); drv(2, 0, 0); qpush(0, 9'h007); qpush(2, 9'h007);
        wait_idle(2, FR0 + 10);
        chk("e_frame_len", cyc - last_start[2], FR0);
`ifdef UART_TX_PARITY_EN
        chk("e_par_even", last_par[0], 1);
        chk("e_par_odd", last_par[2], 0);
`endif
        wait_idle(0, 10);

        // asynchronous reset in the middle of a data bit with three queued
        drv(1, 1, 9'h000); @(negedge clk); qpush(1, 9'h000);
        drv(1, 1, 9'h081); @(negedge clk); qpush(1, 9'h081);
        drv(1, 1, 9'h042); @(negedge clk); qpush(1, 9'h042);
        drv(1, 1, 9'h024); @(negedge clk); qpush(1, 9'h024);
        drv(1, 0, 0);
        repeat (12) @(negedge clk);
        chk("f_level_pre", lvl_w[1], 3);
        chk("f_tx_pre", tx_w[1], 0);
        #2 rst_n[1] = 1'b0;
        q1.delete();
        #1;
        chk("f_tx_async", tx_w[1], 1);
        chk("f_level_rst", lvl_w[1], 0);
        chk("f_busy_rst", busy_w[1], 0);
        repeat (2) @(negedge clk);
        rst_n[1] = 1'b1;
        lows = 0;
        repeat (3 * FR1) begin
            @(negedge clk);
            if (tx_w[1] !== 1'b1) lows++;
        end
        chk("f_no_frames", lows, 0);
        chk("f_idle", busy_w[1], 0);
        chk("f_level_after", lvl_w[1], 0);

        chk("sb_drain", q0.size() + q1.size() + q2.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Parametrised, buffered UART transmitter: accepts DATA_BITS-wide characters through a load/ready handshake into an internal FIFO and serialises them LSB-first onto tx. Each frame is one start bit, DATA_BITS data bits, an optional parity bit and STOP_BITS stop bits, each lasting exactly CLK_DIV clocks. It replaces the fixed 7-bit, unbuffered transmitter on the console path, so the CPU I/O unit can queue characters without waiting out each frame.

## Interface
- CLK_DIV, 32: clocks per bit period, legal range 2..65535.
- DATA_BITS, 7: character width, legal range 5..9.
- STOP_BITS, 1: stop bits per frame, 1 or 2.
- FIFO_DEPTH, 8: character buffer depth, a power of two ≥ 2.
- PARITY_ODD, 0: 1 selects odd parity, 0 selects even. Ignored unless UART_TX_PARITY_EN is defined.
- clk  in  1  sole clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load  in  1  write strobe; a character is accepted on an edge where load & ready.
- in  in  DATA_BITS  character to queue; sampled on the accepting edge.
- ready  out  1  FIFO not full.
- tx  out  1  serial line; idles high.
- busy  out  1  a frame is in progress or the FIFO is non-empty.
- level  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy, 0..FIFO_DEPTH.

## Operation
- Reset values: tx=1, ready=1, busy=0, level=0. The FIFO is emptied, the FSM goes to IDLE and both counters clear.
- FSM states and transitions:
  - IDLE → START when the FIFO is non-empty. The head is popped into the shift register on that edge.
  - START → DATA after one bit period.
  - DATA → PARITY (macro defined) or STOP after DATA_BITS bit periods.
  - PARITY → STOP after one bit period.
  - STOP → START if the FIFO is non-empty (pop on the same edge), otherwise → IDLE, after STOP_BITS bit periods.
- tx per state: 0 in START; shift register bit 0 in DATA (shift right at each bit end); computed parity bit in PARITY; 1 in STOP and IDLE.
- Baud counter: width $clog2(CLK_DIV). It counts 0..CLK_DIV-1 in every non-IDLE state, wraps to 0 at the bit end and is held at 0 in IDLE.
- Bit counter: counts bits within DATA and within STOP. It resets on each state change.
- Load when full (ready=0) is ignored, and the character is dropped. ready is plain !full: a simultaneous pop does not make a full FIFO accept.
- Load while not full is accepted in any FSM state, including on the same edge as a pop. In that case level is unchanged.
- Reset asserted mid-frame: tx goes to 1 immediately (asynchronously), and the partial frame and all queued characters are discarded.
- Changes on in or load outside the accepting edge have no effect on frames already queued.

## Timing
- Character accepted into an empty FIFO at edge k, FSM in IDLE: pop at edge k+1, so tx falls after edge k+1. One idle cycle is the fixed latency.
- Frame length is (1 + DATA_BITS + P + STOP_BITS)·CLK_DIV clocks, where P=1 only with the macro.
- Back-to-back frames have zero gap: the next start bit begins the cycle after the last stop-bit cycle.
- ready falls the cycle after the edge that makes level = FIFO_DEPTH. It rises the cycle after the pop that frees a slot.
- level is registered and updates on the accepting or popping edge.
- busy falls the cycle after the final stop-bit cycle when the FIFO is empty.

## Configuration
- UART_TX_PARITY_EN defined: PARITY state present. Parity bit = XOR of the data bits, inverted when PARITY_ODD=1.
- UART_TX_PARITY_EN undefined: no PARITY state, no parity logic, and PARITY_ODD has no effect. Frame length drops by CLK_DIV.

## Structure
- Shared package uart_pkg holds:
  - FSM state encoding: IDLE, START, DATA, PARITY, STOP.
  - Frame-length helper function.
  - Legal-range constants for DATA_BITS and STOP_BITS, shared with the future receiver.
- Sub-module sync_fifo (parameters WIDTH, DEPTH) holds the storage, read/write pointers with one extra wrap bit, full/empty and level. The top level keeps the FSM, counters and shift register.

## Test plan
- Defaults, CLK_DIV=4, load 7'h55 after reset → tx falls one cycle after acceptance; bits 0,1,0,1,0,1,0,1,1 each held exactly 4 clocks; busy then falls.
- DATA_BITS=8, STOP_BITS=2, queue 8'hA5, 8'h3C, 8'hFF back-to-back → three contiguous frames, no idle gap, each 44 clocks at CLK_DIV=4.
- FIFO_DEPTH=4, five loads during one frame → ready low after the fourth accepted load; fifth character dropped; level reads 4 and then 3 after the next pop.
- Load on the same edge as a pop with level=2 → level stays 2; ready stays 1; order of transmitted characters preserved.
- Macro defined, PARITY_ODD=0, char 7'h07 → parity bit 1; PARITY_ODD=1 → parity bit 0; frame is one bit period longer than without the macro.
- rst_n pulsed low mid-DATA with 3 queued → tx=1 within the same cycle; level=0; no further frames after release.
